// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of hazard-detection inputs and pipeline-register controls between
// the 5-stage datapath (master) and pipeline_hazard_ctrl (slave).
interface pipeline_hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_memread;
    logic [4:0]  ex_rt;
    logic [1:0]  ex_pcsrc;
    logic        ex_multicycle;
    logic        mem_stall;

    logic        pc_write;
    logic        if_id_write;
    logic        if_id_reset;
    logic        id_ex_write;
    logic        id_ex_reset;
    logic        ex_mem_write;
    logic        ex_mem_reset;
    logic        mem_wb_reset;
    logic [1:0]  state_out;
    logic [15:0] stall_cycles;
    logic [15:0] flush_events;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, ex_pcsrc,
               ex_multicycle, mem_stall,
        input  pc_write, if_id_write, if_id_reset, id_ex_write, id_ex_reset,
               ex_mem_write, ex_mem_reset, mem_wb_reset, state_out,
               stall_cycles, flush_events
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, ex_pcsrc,
               ex_multicycle, mem_stall,
        output pc_write, if_id_write, if_id_reset, id_ex_write, id_ex_reset,
               ex_mem_write, ex_mem_reset, mem_wb_reset, state_out,
               stall_cycles, flush_events
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stalls,
// EX redirects, multi-cycle EX holds, memory wait states. Optional stats: HAZARD_STATS_EN.
module pipeline_hazard_ctrl #(
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic clock,
    input  logic reset,
    pipeline_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MULTI = 2'd1
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(MULDIV_LAT - 2);

    state_e     state_q, state_d;
    logic [3:0] count_q, count_d;

    logic pc_write, if_id_write, if_id_reset, id_ex_write, id_ex_reset;
    logic ex_mem_write, ex_mem_reset, mem_wb_reset;
    logic load_use;

    assign load_use = bus.ex_memread && (bus.ex_rt != 5'd0) &&
                      ((bus.ex_rt == bus.id_rs) ||
                       (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

    always_ff @(posedge clock) begin
        state_q <= state_d;
        count_q <= count_d;
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_reset  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_reset  = 1'b0;
        ex_mem_write = 1'b1;
        ex_mem_reset = 1'b0;
        mem_wb_reset = 1'b0;
        state_d      = state_q;
        count_d      = count_q;

        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_reset  = 1'b1;
            id_ex_write  = 1'b0;
            id_ex_reset  = 1'b1;
            ex_mem_write = 1'b0;
            ex_mem_reset = 1'b1;
            mem_wb_reset = 1'b1;
            state_d      = RUN;
            count_d      = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.mem_stall) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_write = 1'b0;
                        mem_wb_reset = 1'b1;
                    end else if (bus.ex_pcsrc != 2'b00) begin
                        if_id_reset = 1'b1;
                        id_ex_reset = 1'b1;
                    end else if (bus.ex_multicycle) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_reset = 1'b1;
                        state_d      = MULTI;
                        count_d      = CNT_INIT;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_reset = 1'b1;
                    end
                end
                MULTI: begin
                    // Redirect and load-use are not evaluated while EX is occupied.
                    if (bus.mem_stall) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_write = 1'b0;
                        mem_wb_reset = 1'b1;
                    end else if (count_q != 4'd0) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_reset = 1'b1;
                        count_d      = count_q - 4'd1;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    count_d = '0;
                end
            endcase
        end
    end

    assign bus.pc_write     = pc_write;
    assign bus.if_id_write  = if_id_write;
    assign bus.if_id_reset  = if_id_reset;
    assign bus.id_ex_write  = id_ex_write;
    assign bus.id_ex_reset  = id_ex_reset;
    assign bus.ex_mem_write = ex_mem_write;
    assign bus.ex_mem_reset = ex_mem_reset;
    assign bus.mem_wb_reset = mem_wb_reset;
    assign bus.state_out    = state_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;
    logic        redirect_taken;

    assign redirect_taken = (state_q == RUN) && !bus.mem_stall &&
                            (bus.ex_pcsrc != 2'b00);

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (reset) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (!pc_write && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
            if (redirect_taken && (flush_q != 16'hFFFF)) flush_d = flush_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        stall_q <= stall_d;
        flush_q <= flush_d;
    end

    assign bus.stall_cycles = stall_q;
    assign bus.flush_events = flush_q;
`else
    assign bus.stall_cycles = '0;
    assign bus.flush_events = '0;
`endif

endmodule
